pipe_rca_adder: RTL and testbench



---
 rtl/pipe_rca_pkg.sv | 16 +
 rtl/rca_slice.sv | 29 ++
 rtl/pipe_rca_adder.sv | 137 +++++++++++++
 tb/tb_pipe_rca_adder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_rca_pkg.sv
// Shared defaults and helpers for the pipelined ripple-carry adder.
// Holds default WIDTH/STAGES, the SLICE width function and the divisibility check.
package pipe_rca_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit slice_ok(input int width, input int stages);
        return (stages > 0) && (width > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational W-bit ripple-carry slice built from per-bit full adders.
// Ports: a, b operands; cin carry-in; sum; cout carry-out; cmsb carry into top bit.
module rca_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[W];
    assign cmsb = c[W-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor, one SLICE resolved per stage.
// Ports: clk, rst_n; in_valid/in_ready, x, y, ci, sub; out_valid/out_ready, s, co, ovf.
module pipe_rca_adder
    import pipe_rca_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int SLICE = slice_width(WIDTH, STAGES);

    if (!slice_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_rca_adder: WIDTH must be a multiple of STAGES");
    end

    logic             en;
    logic [WIDTH-1:0] y_inv;
    logic             cin0;

    // The whole pipe moves together; only a held result can stall it.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;
    assign y_inv    = sub ? ~y : y;
    assign cin0     = sub | ci;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int DW = (k + 1) * SLICE;
        localparam int RW = WIDTH - DW;

        logic [SLICE-1:0] a_sl;
        logic [SLICE-1:0] b_sl;
        logic [SLICE-1:0] s_sl;
        logic             c_in;
        logic             c_out;
        logic             c_msb;
        logic             vld_d;
        logic             vld_q;
        logic             c_q;
        logic [DW-1:0]    s_d;
        logic [DW-1:0]    s_q;

        if (k == 0) begin : g_in
            assign a_sl  = x[SLICE-1:0];
            assign b_sl  = y_inv[SLICE-1:0];
            assign c_in  = cin0;
            assign vld_d = in_valid;
            assign s_d   = s_sl;
        end else begin : g_in
            assign a_sl  = g_st[k-1].g_op.a_q[SLICE-1:0];
            assign b_sl  = g_st[k-1].g_op.b_q[SLICE-1:0];
            assign c_in  = g_st[k-1].c_q;
            assign vld_d = g_st[k-1].vld_q;
            assign s_d   = {s_sl, g_st[k-1].s_q};
        end

        rca_slice #(
            .W(SLICE)
        ) u_slice (
            .a   (a_sl),
            .b   (b_sl),
            .cin (c_in),
            .sum (s_sl),
            .cout(c_out),
            .cmsb(c_msb)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                s_q   <= '0;
            end else if (en) begin
                vld_q <= vld_d;
                c_q   <= c_out;
                s_q   <= s_d;
            end
        end

        // Operand skew: only the slices not yet summed travel onward.
        if (k < STAGES - 1) begin : g_op
            logic [RW-1:0] a_d;
            logic [RW-1:0] b_d;
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;

            if (k == 0) begin : g_src
                assign a_d = x[WIDTH-1:SLICE];
                assign b_d = y_inv[WIDTH-1:SLICE];
            end else begin : g_src
                assign a_d = g_st[k-1].g_op.a_q[RW+SLICE-1:SLICE];
                assign b_d = g_st[k-1].g_op.b_q[RW+SLICE-1:SLICE];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= c_msb ^ c_out;
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].vld_q;
    assign s         = g_st[STAGES-1].s_q;
    assign co        = g_st[STAGES-1].c_q;
    assign ovf       = g_st[STAGES-1].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Directed bench for pipe_rca_adder at WIDTH=16, STAGES=4.
// Covers reset, latency, carry/overflow, subtract, backpressure and mid-stream reset.
module tb_pipe_rca_adder;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    pipe_rca_adder #(
        .WIDTH (W),
        .STAGES(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x        (x),
        .y        (y),
        .ci       (ci),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .s        (s),
        .co       (co),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            x         = W'($urandom);
            y         = W'($urandom);
            ci        = 1'($urandom);
            sub       = 1'($urandom);
            cyc();
            total_cnt++;
            if ({out_valid, s, co, ovf, in_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b1})
                $display("FAIL reset_state: got v=%b s=%h co=%b ovf=%b rdy=%b want 0 0000 0 0 1",
                         out_valid, s, co, ovf, in_ready);
            else pass_cnt++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            total_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL reset_release_idle: out_valid=%b want 0", out_valid);
            else pass_cnt++;
        end
    endtask

    task automatic test_single();
        x = 16'h0001; y = 16'h0002; ci = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b want 1", in_ready);
        else pass_cnt++;
        for (int t = 0; t < 5; t++) begin
            cyc();
            in_valid = 1'b0;
            total_cnt++;
            if (t == 3) begin
                if ({out_valid, s, co, ovf} !== {1'b1, 16'h0003, 1'b0, 1'b0})
                    $display("FAIL single_result: got v=%b s=%h co=%b ovf=%b want 1 0003 0 0",
                             out_valid, s, co, ovf);
                else pass_cnt++;
            end else begin
                if (out_valid !== 1'b0)
                    $display("FAIL single_latency t=%0d: out_valid=%b want 0", t, out_valid);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_carry_ovf();
        logic [W-1:0] vx [3] = '{16'hFFFF, 16'h7FFF, 16'h00FF};
        logic [W-1:0] vy [3] = '{16'h0001, 16'h0001, 16'h0F01};
        logic         vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [W-1:0] es [3] = '{16'h0000, 16'h8000, 16'h1001};
        logic         eco[3] = '{1'b1, 1'b0, 1'b0};
        logic         eov[3] = '{1'b0, 1'b1, 1'b0};
        sub = 1'b0;
        for (int t = 0; t < 7; t++) begin
            in_valid = (t < 3);
            if (t < 3) begin x = vx[t]; y = vy[t]; ci = vc[t]; end
            cyc();
            total_cnt++;
            if (t >= 3 && t < 6) begin
                if ({out_valid, s, co, ovf} !== {1'b1, es[t-3], eco[t-3], eov[t-3]})
                    $display("FAIL carry_op%0d: got v=%b s=%h co=%b ovf=%b want 1 %h %b %b",
                             t - 3, out_valid, s, co, ovf, es[t-3], eco[t-3], eov[t-3]);
                else pass_cnt++;
            end else begin
                if (out_valid !== 1'b0)
                    $display("FAIL carry_idle t=%0d: out_valid=%b want 0", t, out_valid);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_subtract();
        logic [W-1:0] vx [2] = '{16'h0005, 16'h8000};
        logic [W-1:0] vy [2] = '{16'h0007, 16'h0001};
        logic [W-1:0] es [2] = '{16'hFFFE, 16'h7FFF};
        logic         eco[2] = '{1'b0, 1'b1};
        logic         eov[2] = '{1'b0, 1'b1};
        sub = 1'b1;
        ci  = 1'b1;
        for (int t = 0; t < 6; t++) begin
            in_valid = (t < 2);
            if (t < 2) begin x = vx[t]; y = vy[t]; end
            cyc();
            total_cnt++;
            if (t >= 3 && t < 5) begin
                if ({out_valid, s, co, ovf} !== {1'b1, es[t-3], eco[t-3], eov[t-3]})
                    $display("FAIL sub_op%0d: got v=%b s=%h co=%b ovf=%b want 1 %h %b %b",
                             t - 3, out_valid, s, co, ovf, es[t-3], eco[t-3], eov[t-3]);
                else pass_cnt++;
            end else begin
                if (out_valid !== 1'b0)
                    $display("FAIL sub_idle t=%0d: out_valid=%b want 0", t, out_valid);
                else pass_cnt++;
            end
        end
        sub = 1'b0;
        ci  = 1'b0;
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got  = 0;
        int stall_left = 0;
        bit stalled_once = 1'b0;
        int low_cycles = 0;
        sub = 1'b0;
        ci  = 1'b0;
        for (int cy = 0; cy < 60 && got < 8; cy++) begin
            if (out_valid && !stalled_once) begin
                stalled_once = 1'b1;
                stall_left   = 3;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < 8);
            x = W'(sent);
            y = W'(sent);
            #1;
            total_cnt++;
            if (in_ready !== (stall_left == 0))
                $display("FAIL bp_in_ready cy=%0d: got %b want %b", cy, in_ready, stall_left == 0);
            else pass_cnt++;
            if (!in_ready) low_cycles++;
            if (out_valid && out_ready) begin
                total_cnt++;
                if (s !== W'(2 * got))
                    $display("FAIL bp_order idx=%0d: got %h want %h", got, s, W'(2 * got));
                else pass_cnt++;
                got++;
            end
            if (in_valid && in_ready) sent++;
            if (stall_left > 0) stall_left--;
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total_cnt++;
        if (got !== 8 || low_cycles !== 3)
            $display("FAIL bp_counts: got %0d results %0d stall cycles want 8 and 3", got, low_cycles);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            #1;
            total_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL bp_extra: out_valid=%b s=%h want no further result", out_valid, s);
            else pass_cnt++;
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        sub = 1'b0;
        ci  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            x = W'(16 * (i + 1));
            y = 16'h0001;
            cyc();
        end
        total_cnt++;
        if ({out_valid, s} !== {1'b1, 16'h0011})
            $display("FAIL midrst_pre: got v=%b s=%h want 1 0011", out_valid, s);
        else pass_cnt++;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        total_cnt++;
        if ({out_valid, s} !== {1'b0, 16'h0000})
            $display("FAIL midrst_drop: got v=%b s=%h want 0 0000", out_valid, s);
        else pass_cnt++;
        cyc();
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            total_cnt++;
            if (out_valid !== 1'b0)
                $display("FAIL midrst_stale i=%0d: out_valid=%b s=%h want 0", i, out_valid, s);
            else pass_cnt++;
        end
        in_valid = 1'b1;
        x = 16'h0003;
        y = 16'h0004;
        for (int t = 0; t < 4; t++) begin
            cyc();
            in_valid = 1'b0;
        end
        total_cnt++;
        if ({out_valid, s} !== {1'b1, 16'h0007})
            $display("FAIL midrst_after: got v=%b s=%h want 1 0007", out_valid, s);
        else pass_cnt++;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; y = '0; ci = 1'b0; sub = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_carry_ovf();
        test_subtract();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
